// File: rtl/rr_arbiter4_pkg.sv
// Shared types and helpers for the four-way round-robin arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rr_arbiter4_pkg;

    localparam int NUM_REQ = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // 2-bit index -> one-hot, inverse of the 4-to-2 encoder mapping (0->0001 ... 3->1000).
    function automatic logic [NUM_REQ-1:0] onehot4(input logic [1:0] idx);
        logic [NUM_REQ-1:0] oh;
        oh = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/rr_arbiter4_pick.sv
// Round-robin winner selection: scans last+1, last+2, last+3, last (mod 4).
// Latency: combinational.
// Backpressure: none; caller decides when to use the result.
module rr_pick4
    import rr_arbiter4_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [1:0]         last,
    output logic [1:0]         winner,
    output logic               any
);

    logic [1:0] idx;

    // Scan from farthest to nearest so the nearest set bit after last overwrites the rest.
    always_comb begin
        winner = 2'd0;
        any    = 1'b0;
        idx    = 2'd0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = last + 2'(k) + 2'd1;
            if (req[idx]) begin
                winner = idx;
                any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter with registered one-hot grant, encoded index and optional hold limit.
// Latency: one cycle from sampled request (IDLE) to grant; one idle cycle after every release.
// Backpressure: enable gates only new grants; an active grant is held until request drop or hold limit.
module rr_arbiter4
    import rr_arbiter4_pkg::*;
#(
    parameter int MAX_HOLD = 0,
    parameter int CW       = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [1:0]         gnt_id,
    output logic               gnt_valid,
    output logic               timeout
);

    localparam logic          HOLD_LIMITED = (MAX_HOLD != 0);
    localparam logic [CW-1:0] HOLD_MAX     = CW'(MAX_HOLD);
    localparam logic [CW-1:0] CNT_SAT      = '1;

    state_t             state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [1:0]         gnt_id_q, gnt_id_d;
    logic               timeout_q, timeout_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [1:0]         last_q, last_d;

    logic [1:0]         pick_winner;
    logic               pick_any;

    rr_pick4 u_pick (
        .req    (req),
        .last   (last_q),
        .winner (pick_winner),
        .any    (pick_any)
    );

    // Next-state and registered-output computation; gnt_id_q doubles as the current winner.
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        gnt_id_d  = gnt_id_q;
        timeout_d = 1'b0;
        cnt_d     = cnt_q;
        last_d    = last_q;
        case (state_q)
            IDLE: begin
                gnt_d    = '0;
                gnt_id_d = 2'd0;
                cnt_d    = '0;
                if (enable && pick_any) begin
                    state_d  = GRANT;
                    gnt_d    = onehot4(pick_winner);
                    gnt_id_d = pick_winner;
                    cnt_d    = CW'(1);
                end
            end
            GRANT: begin
                if (!req[gnt_id_q]) begin
                    state_d  = IDLE;
                    gnt_d    = '0;
                    gnt_id_d = 2'd0;
                    cnt_d    = '0;
                    last_d   = gnt_id_q;
                end else if (HOLD_LIMITED && (cnt_q == HOLD_MAX)) begin
                    state_d   = IDLE;
                    gnt_d     = '0;
                    gnt_id_d  = 2'd0;
                    cnt_d     = '0;
                    last_d    = gnt_id_q;
                    timeout_d = 1'b1;
                end else if (cnt_q != CNT_SAT) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d  = IDLE;
                gnt_d    = '0;
                gnt_id_d = 2'd0;
                cnt_d    = '0;
            end
        endcase
    end

    // State and output registers; last resets to 3 so requester 0 wins first.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            gnt_id_q  <= 2'd0;
            timeout_q <= 1'b0;
            cnt_q     <= '0;
            last_q    <= 2'd3;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            gnt_id_q  <= gnt_id_d;
            timeout_q <= timeout_d;
            cnt_q     <= cnt_d;
            last_q    <= last_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_id    = gnt_id_q;
    assign gnt_valid = |gnt_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_rr_arbiter4.sv
// Directed bench for rr_arbiter4: one instance with unlimited hold, one with MAX_HOLD=4.
// Latency: checks taken 1 time unit after each rising edge.
// Backpressure: exercised through enable gating and request drops.
module tb_rr_arbiter4;

    logic       clk = 1'b0;
    logic       rst_a, en_a, rst_b, en_b;
    logic [3:0] req_a, req_b;
    logic [3:0] gnt_a, gnt_b;
    logic [1:0] id_a, id_b;
    logic       vld_a, vld_b, to_a, to_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    rr_arbiter4 #(.MAX_HOLD(0), .CW(8)) dut_a (
        .clk(clk), .rst(rst_a), .enable(en_a), .req(req_a),
        .gnt(gnt_a), .gnt_id(id_a), .gnt_valid(vld_a), .timeout(to_a)
    );

    rr_arbiter4 #(.MAX_HOLD(4), .CW(8)) dut_b (
        .clk(clk), .rst(rst_b), .enable(en_b), .req(req_b),
        .gnt(gnt_b), .gnt_id(id_b), .gnt_valid(vld_b), .timeout(to_b)
    );

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_a(input string tag, input logic [3:0] g, input logic [1:0] id, input logic to);
        check({tag, ".gnt"}, 8'(gnt_a), 8'(g));
        check({tag, ".id"},  8'(id_a),  8'(id));
        check({tag, ".vld"}, 8'(vld_a), 8'(|g));
        check({tag, ".to"},  8'(to_a),  8'(to));
    endtask

    task automatic check_b(input string tag, input logic [3:0] g, input logic [1:0] id, input logic to);
        check({tag, ".gnt"}, 8'(gnt_b), 8'(g));
        check({tag, ".id"},  8'(id_b),  8'(id));
        check({tag, ".vld"}, 8'(vld_b), 8'(|g));
        check({tag, ".to"},  8'(to_b),  8'(to));
    endtask

    logic [3:0] rr_order [5];
    logic [1:0] rr_ids   [5];
    logic [3:0] to_order [3];
    logic [1:0] to_ids   [3];

    initial begin
        rr_order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        rr_ids   = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        to_order = '{4'b0100, 4'b1000, 4'b0001};
        to_ids   = '{2'd2, 2'd3, 2'd0};

        rst_a = 1'b1; en_a = 1'b1; req_a = 4'b1111;
        rst_b = 1'b1; en_b = 1'b1; req_b = 4'b0000;

        // 1. Reset with all requesting, then first grant goes to requester 0.
        tick(); tick();
        check_a("reset", 4'b0000, 2'd0, 1'b0);
        rst_a = 1'b0;
        tick();

        // 2. Round robin with unlimited hold; each holder drops for one cycle after 3 cycles.
        for (int g = 0; g < 5; g++) begin
            check_a("rr_hold1", rr_order[g], rr_ids[g], 1'b0);
            tick();
            check_a("rr_hold2", rr_order[g], rr_ids[g], 1'b0);
            tick();
            check_a("rr_hold3", rr_order[g], rr_ids[g], 1'b0);
            req_a = 4'b1111 & ~rr_order[g];
            tick();
            check_a("rr_gap", 4'b0000, 2'd0, 1'b0);
            req_a = (g < 4) ? 4'b1111 : 4'b0000;
            if (g < 4) tick();
        end

        // 3. Hold limit: single requester gets 4 cycles, timeout pulse, regrant after one idle cycle.
        rst_b = 1'b0; req_b = 4'b0100;
        tick();
        for (int c = 0; c < 4; c++) begin
            check_b("to_hold", 4'b0100, 2'd2, 1'b0);
            if (c < 3) tick();
        end
        tick();
        check_b("to_pulse", 4'b0000, 2'd0, 1'b1);
        tick();
        check_b("to_regrant", 4'b0100, 2'd2, 1'b0);
        // All four requesting under the limit: 2, 3, 0 each for 4 cycles.
        req_b = 4'b1111;
        for (int g = 0; g < 3; g++) begin
            for (int c = (g == 0) ? 1 : 0; c < 4; c++) begin
                if (c > 0) tick();
                check_b("to_all_hold", to_order[g], to_ids[g], 1'b0);
            end
            tick();
            check_b("to_all_pulse", 4'b0000, 2'd0, 1'b1);
            tick();
        end
        req_b = 4'b0000;

        // 4. Enable gating: no new grant while low, held grant survives enable drop.
        en_a = 1'b0; req_a = 4'b0010;
        tick(); tick();
        check_a("en_off", 4'b0000, 2'd0, 1'b0);
        en_a = 1'b1;
        tick();
        check_a("en_on", 4'b0010, 2'd1, 1'b0);
        en_a = 1'b0;
        tick();
        check_a("en_drop1", 4'b0010, 2'd1, 1'b0);
        tick();
        check_a("en_drop2", 4'b0010, 2'd1, 1'b0);
        req_a = 4'b0000;
        tick();
        check_a("en_release", 4'b0000, 2'd0, 1'b0);

        // 5. Pointer fairness: after requester 2 releases, 0 beats 2.
        en_a = 1'b1; req_a = 4'b0100;
        tick();
        check_a("ptr_g2", 4'b0100, 2'd2, 1'b0);
        req_a = 4'b0000;
        tick();
        req_a = 4'b0101;
        tick();
        check_a("ptr_wrap", 4'b0001, 2'd0, 1'b0);
        req_a = 4'b0000;
        tick();

        // 6. Reset during a grant restores last=3.
        req_a = 4'b1000;
        tick();
        check_a("mid_g3", 4'b1000, 2'd3, 1'b0);
        rst_a = 1'b1;
        tick();
        check_a("mid_rst", 4'b0000, 2'd0, 1'b0);
        rst_a = 1'b0; req_a = 4'b1001;
        tick();
        check_a("mid_after", 4'b0001, 2'd0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rr_arbiter4.md
Name: rr_arbiter4

Overview:
Round-robin arbiter that shares one downstream resource (e.g. the 4-to-2 encoder datapath / a shared output bus) between four requesters.
- Registered one-hot grant plus its binary-encoded index, using the same 4-to-2 mapping as the team's encoder: req0→00, req1→01, req2→10, req3→11.
- Grant is held while the winner keeps its request asserted, subject to an optional hold-time limit.
- Enable gates new arbitration only; it never revokes an active grant.

Parameters:
MAX_HOLD, 0, maximum grant length in cycles (1..255); 0 = unlimited hold.
CW, 8, width of hold counter; MAX_HOLD must be < 2**CW.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  synchronous active-high reset.
enable  input  1  1 = arbitration allowed in IDLE; 0 = no new grant issued.
req  input  4  request vector, bit i = requester i; level-sensitive.
gnt  output  4  one-hot grant (registered); all-zero when no grant.
gnt_id  output  2  encoded index of granted requester; 00 when gnt_valid=0.
gnt_valid  output  1  1 while any grant is active (= |gnt).
timeout  output  1  single-cycle pulse on the cycle a grant is revoked by MAX_HOLD.

Behaviour:
Reset and clocking:
- One clock domain. Reset is synchronous and active-high, sampled on the rising edge of clk.
- Reset values: gnt=0000, gnt_id=00, gnt_valid=0, timeout=0, state=IDLE, hold counter=0, last pointer=3 (so requester 0 has top priority after reset).
- rst asserted during GRANT: grant drops the following edge; no timeout pulse.

FSM states: IDLE, GRANT.

IDLE:
- If enable=1 and req!=0: choose the winner by scanning indices last+1, last+2, last+3, last (mod 4); first set bit wins.
- Next cycle: state=GRANT, gnt=onehot(winner), gnt_id=winner, gnt_valid=1, counter=1.
- Otherwise remain in IDLE with outputs at 0.

GRANT (winner w):
- If req[w]=0: release. Next cycle state=IDLE, gnt=0, last=w.
- Else if MAX_HOLD!=0 and counter==MAX_HOLD: forced release. Next cycle state=IDLE, gnt=0, last=w, timeout=1 for exactly that cycle.
- Else: hold the grant and increment the counter, saturating at 2**CW-1 when MAX_HOLD=0.
- enable and req[j≠w] are ignored in GRANT.

Timing and boundaries:
- Latency: req rises at edge k (sampled in IDLE) → gnt valid after edge k+1. Release always inserts exactly one idle cycle (gnt=0) between consecutive grants, including back-to-back grants to different requesters.
- A requester that dropped and re-raised req in the same cycle is not detectable (level-sensitive); the grant is simply held.
- last is updated only on release, never in IDLE.
- All four requesting continuously with MAX_HOLD=0: each holder keeps the grant until it drops its request.
- All four requesting continuously with MAX_HOLD>0: order 0,1,2,3,0,… each for MAX_HOLD cycles.
- Single requester with timeout: it is re-granted after the one idle cycle.
- enable=0 while in GRANT: the current grant continues; no new grant is issued after release until enable=1.
- Outputs are pure registers; no combinational req→gnt path.

Decomposition:
- Shared package: state encoding constants (IDLE=1'b0, GRANT=1'b1) and the requester count (4).
- One sub-module is natural: rr_pick4 (combinational). Inputs req[3:0] and last[1:0]; outputs winner[1:0] and any. It internally reuses the 4-to-2 encoding.
- FSM, counter and output registers stay in rr_arbiter4.

Test Plan:
1. Reset: rst=1 for 2 cycles with req=1111 → gnt=0000, gnt_valid=0, timeout=0. Release rst, then next edge → gnt=0001, gnt_id=00.
2. Round robin (MAX_HOLD=0): req=1111 and each holder drops its req for 1 cycle after 3 grant cycles → grant order 0001,0010,0100,1000,0001, with a 1-cycle gnt=0000 gap between grants.
3. Timeout (MAX_HOLD=4): req=0100 held high → gnt=0100 for 4 cycles, timeout=1 on the cycle gnt=0000, then gnt=0100 again one cycle later.
4. Enable gating: enable=0, req=0010 → gnt stays 0000. Raise enable → gnt=0010 next cycle. Drop enable mid-grant → grant retained while req[1]=1.
5. Pointer fairness: after a grant to 2 is released, req=0101 → gnt=0001 (index 0 follows 3 in the scan), not 0100.
6. Mid-grant reset: gnt=1000 active, assert rst for 1 cycle → gnt=0000, timeout=0, last=3. Next grant with req=1001 → 0001.
